// File: rtl/reg_access_arbiter_if.sv
// Requester and shared-register bus of the register access arbiter; ARB_LOCK_EN adds req_lock.
// Latency: none, wires only.
// Backpressure: none; requesters hold req level until their done pulse.
interface reg_access_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [3*NUM_REQ-1:0]  req_funSel;
    logic [32*NUM_REQ-1:0] req_data;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]    req_lock;
`endif
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic [31:0]           rsp_data;
    logic                  busy;
    logic                  reg_enable;
    logic [2:0]            reg_funSel;
    logic [31:0]           reg_i;
    logic [31:0]           reg_o;

    modport master (
        input  req, req_funSel, req_data, reg_o,
`ifdef ARB_LOCK_EN
               req_lock,
`endif
        output gnt, done, rsp_data, busy, reg_enable, reg_funSel, reg_i
    );

    modport slave (
        output req, req_funSel, req_data, reg_o,
`ifdef ARB_LOCK_EN
               req_lock,
`endif
        input  gnt, done, rsp_data, busy, reg_enable, reg_funSel, reg_i
    );
endinterface

// File: rtl/reg_access_arbiter.sv
// Round-robin sequencer sharing one function-select register; ARB_LOCK_EN adds requester lock.
// Latency: gnt 1 cycle after req sampled in IDLE, reg_enable 1 later, done 1 after that; 4 cycles/op.
// Backpressure: req is a held level; only sampled in IDLE, operands latched at selection.
module reg_access_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    reg_access_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT, ISSUE, RESP} state_t;

    state_t             state, nxt;
    logic [PTR_W-1:0]   ptr, win, base, sel_idx, cand;
    logic               sel_vld;
    logic [2:0]         sel_fs, lat_fs, fs_q;
    logic [31:0]        sel_dat, lat_dat, i_q;
    logic [NUM_REQ-1:0] gnt_q, done_q;
    logic               busy_q, en_q;
`ifdef ARB_LOCK_EN
    logic               lock_q;
`endif

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
`ifdef ARB_LOCK_EN
        // A pending lock resumes rotation from the locked winner, not the held ptr
        base = lock_q ? inc_ptr(win) : ptr;
`else
        base = ptr;
`endif
        sel_vld = |bus.req;
        sel_idx = base;
        cand    = base;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = PTR_W'((int'(base) + i) % NUM_REQ);
            if (bus.req[cand]) sel_idx = cand;
        end
`ifdef ARB_LOCK_EN
        if (lock_q && bus.req[win]) sel_idx = win;
`endif
        sel_fs  = '0;
        sel_dat = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (PTR_W'(k) == sel_idx) begin
                sel_fs  = bus.req_funSel[3*k +: 3];
                sel_dat = bus.req_data[32*k +: 32];
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (sel_vld) nxt = GRANT;
            GRANT:   nxt = ISSUE;
            ISSUE:   nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            win     <= '0;
            lat_fs  <= '0;
            lat_dat <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            fs_q    <= '0;
            i_q     <= '0;
`ifdef ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            en_q   <= 1'b0;
            busy_q <= (nxt != IDLE);
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        win     <= sel_idx;
                        lat_fs  <= sel_fs;
                        lat_dat <= sel_dat;
                        gnt_q   <= NUM_REQ'(1) << sel_idx;
`ifdef ARB_LOCK_EN
                        lock_q  <= 1'b0;
                    end else if (lock_q) begin
                        lock_q  <= 1'b0;
                        ptr     <= inc_ptr(win);
`endif
                    end
                end
                GRANT: begin
                    en_q <= 1'b1;
                    fs_q <= lat_fs;
                    i_q  <= lat_dat;
                end
                ISSUE: done_q <= NUM_REQ'(1) << win;
                RESP: begin
`ifdef ARB_LOCK_EN
                    if (bus.req_lock[win]) lock_q <= 1'b1;
                    else                   ptr    <= inc_ptr(win);
`else
                    ptr <= inc_ptr(win);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.reg_enable = en_q;
    assign bus.reg_funSel = fs_q;
    assign bus.reg_i      = i_q;
    // The register only shows its new value after the ISSUE edge, so the response is passed through in RESP
    assign bus.rsp_data   = (state == RESP) ? bus.reg_o : '0;
endmodule
